// File: rtl/exc_detect.sv
// M-stage exception collector: prioritises per-instruction faults and interrupts,
// drives the CP0 exception write port and the pipeline flush/redirect.
module exc_detect #(
    parameter logic [31:0] EXC_VECTOR  = 32'hBFC00380,
    parameter int          SYNC_STAGES = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        m_valid,
    input  logic [31:0] m_pc,
    input  logic        m_indelayslot,
    input  logic        m_adel_if,
    input  logic        m_ri,
    input  logic        m_syscall,
    input  logic        m_break,
    input  logic        m_ov,
    input  logic        m_eret,
    input  logic        m_ld_misalign,
    input  logic        m_st_misalign,
    input  logic [31:0] m_dataaddr,
    input  logic [5:0]  ext_int,
    input  logic        stall,
    input  logic [31:0] cp0_status,
    input  logic [31:0] cp0_cause,
    input  logic [31:0] cp0_epc,
    output logic        exc_en,
    output logic [5:0]  exc_type,
    output logic [31:0] exc_pc,
    output logic        exc_indelayslot,
    output logic [31:0] exc_badvaddr,
    output logic        flush,
    output logic        flush_d,
    output logic [31:0] newpc,
    output logic [5:0]  int_pending
);

    localparam logic [5:0] EXC_INT       = 6'h00;
    localparam logic [5:0] EXC_ADEL      = 6'h04;
    localparam logic [5:0] EXC_ADES      = 6'h05;
    localparam logic [5:0] EXC_SYS       = 6'h08;
    localparam logic [5:0] EXC_BP        = 6'h09;
    localparam logic [5:0] EXC_RI        = 6'h0a;
    localparam logic [5:0] EXC_OV        = 6'h0c;
    localparam logic [5:0] EXC_TYPE_ERET = 6'h0e;

    typedef enum logic {IDLE, SHADOW} state_t;

    state_t                         state;
    logic                           flush_q;
    logic [SYNC_STAGES-1:0][5:0]    sync_q;
    logic [5:0]                     int_sync;
    logic                           int_req;
    logic                           hit;
    logic                           take;
    logic [5:0]                     code;
    logic [31:0]                    bad;

    always_ff @(posedge clk) begin
        if (rst) begin
            sync_q <= '0;
        end else begin
            sync_q[0] <= ext_int;
            for (int i = 1; i < SYNC_STAGES; i++)
                sync_q[i] <= sync_q[i-1];
        end
    end

    assign int_sync = sync_q[SYNC_STAGES-1];
    assign int_req  = cp0_status[0] & ~cp0_status[1] &
                      (|({int_sync, cp0_cause[9:8]} & cp0_status[15:8]));

    always_comb begin
        hit  = 1'b0;
        code = EXC_INT;
        bad  = '0;
        if (m_valid) begin
            hit = 1'b1;
            if (int_req)             code = EXC_INT;
            else if (m_adel_if)      begin code = EXC_ADEL; bad = m_pc; end
            else if (m_ri)           code = EXC_RI;
            else if (m_syscall)      code = EXC_SYS;
            else if (m_break)        code = EXC_BP;
            else if (m_ov)           code = EXC_OV;
            else if (m_ld_misalign)  begin code = EXC_ADEL; bad = m_dataaddr; end
            else if (m_st_misalign)  begin code = EXC_ADES; bad = m_dataaddr; end
            else if (m_eret)         code = EXC_TYPE_ERET;
            else                     hit = 1'b0;
        end
    end

    // SHADOW blocks a second take while Status.EXL settles and the pipe drains
    assign take = hit & ~stall & (state == IDLE) & ~rst;

    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= IDLE;
            flush_q <= 1'b0;
        end else begin
            flush_q <= take;
            case (state)
                IDLE:    if (take) state <= SHADOW;
                SHADOW:  state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end

    assign exc_en          = take;
    assign flush           = take;
    assign flush_d         = flush_q & ~rst;
    assign exc_type        = rst ? 6'h00 : code;
    assign exc_pc          = rst ? 32'h0 : m_pc;
    assign exc_indelayslot = m_indelayslot & ~rst;
    assign exc_badvaddr    = rst ? 32'h0 : bad;
    assign newpc           = !take ? 32'h0 :
                             (code == EXC_TYPE_ERET) ? cp0_epc : EXC_VECTOR;
    assign int_pending     = rst ? 6'h00 : int_sync;

endmodule

// File: tb/tb_exc_detect.sv
// Directed-vector bench for exc_detect with hand-computed expectations.
module tb_exc_detect;

    localparam int SYNC_STAGES = 2;

    logic        clk = 1'b0;
    logic        rst;
    logic        m_valid, m_indelayslot, m_adel_if, m_ri, m_syscall, m_break;
    logic        m_ov, m_eret, m_ld_misalign, m_st_misalign, stall;
    logic [31:0] m_pc, m_dataaddr, cp0_status, cp0_cause, cp0_epc;
    logic [5:0]  ext_int;
    logic        exc_en, exc_indelayslot, flush, flush_d;
    logic [5:0]  exc_type, int_pending;
    logic [31:0] exc_pc, exc_badvaddr, newpc;

    int n_tests = 0;
    int n_fail  = 0;

    exc_detect #(.EXC_VECTOR(32'hBFC00380), .SYNC_STAGES(SYNC_STAGES)) dut (
        .clk(clk), .rst(rst), .m_valid(m_valid), .m_pc(m_pc),
        .m_indelayslot(m_indelayslot), .m_adel_if(m_adel_if), .m_ri(m_ri),
        .m_syscall(m_syscall), .m_break(m_break), .m_ov(m_ov), .m_eret(m_eret),
        .m_ld_misalign(m_ld_misalign), .m_st_misalign(m_st_misalign),
        .m_dataaddr(m_dataaddr), .ext_int(ext_int), .stall(stall),
        .cp0_status(cp0_status), .cp0_cause(cp0_cause), .cp0_epc(cp0_epc),
        .exc_en(exc_en), .exc_type(exc_type), .exc_pc(exc_pc),
        .exc_indelayslot(exc_indelayslot), .exc_badvaddr(exc_badvaddr),
        .flush(flush), .flush_d(flush_d), .newpc(newpc), .int_pending(int_pending)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clr();
        m_valid = 0; m_indelayslot = 0; m_adel_if = 0; m_ri = 0; m_syscall = 0;
        m_break = 0; m_ov = 0; m_eret = 0; m_ld_misalign = 0; m_st_misalign = 0;
        m_pc = 32'h0; m_dataaddr = 32'h0; stall = 0;
    endtask

    initial begin
        clr();
        rst = 1; ext_int = 0; cp0_status = 0; cp0_cause = 0; cp0_epc = 0;
        tick(); tick();

        // outputs held at zero during reset even with a live exception
        m_valid = 1; m_syscall = 1; m_pc = 32'hBFC00100; #1;
        chk("rst_en", exc_en, 0);
        chk("rst_flush", flush, 0);
        chk("rst_type", exc_type, 0);
        chk("rst_newpc", newpc, 0);
        chk("rst_pc", exc_pc, 0);
        chk("rst_flushd", flush_d, 0);
        clr(); rst = 0; tick();

        // syscall
        m_valid = 1; m_syscall = 1; m_pc = 32'hBFC00100; #1;
        chk("sys_en", exc_en, 1);
        chk("sys_type", exc_type, 6'h08);
        chk("sys_flush", flush, 1);
        chk("sys_newpc", newpc, 32'hBFC00380);
        chk("sys_pc", exc_pc, 32'hBFC00100);
        tick();
        chk("sys_flushd", flush_d, 1);
        chk("shadow_en", exc_en, 0);
        chk("shadow_flush", flush, 0);
        clr(); tick();
        chk("idle_flushd", flush_d, 0);

        // misaligned load in delay slot
        m_valid = 1; m_ld_misalign = 1; m_dataaddr = 32'h80000003;
        m_pc = 32'hBFC00200; m_indelayslot = 1; #1;
        chk("ld_en", exc_en, 1);
        chk("ld_type", exc_type, 6'h04);
        chk("ld_bad", exc_badvaddr, 32'h80000003);
        chk("ld_ds", exc_indelayslot, 1);
        chk("ld_pc", exc_pc, 32'hBFC00200);
        tick(); clr(); tick();

        // misaligned store
        m_valid = 1; m_st_misalign = 1; m_dataaddr = 32'h80000011; m_pc = 32'hBFC00300; #1;
        chk("st_type", exc_type, 6'h05);
        chk("st_bad", exc_badvaddr, 32'h80000011);
        tick(); clr(); tick();

        // fetch ADEL beats store misalign, badvaddr is the PC
        m_valid = 1; m_adel_if = 1; m_st_misalign = 1; m_pc = 32'hBFC00302;
        m_dataaddr = 32'h12345678; #1;
        chk("if_type", exc_type, 6'h04);
        chk("if_bad", exc_badvaddr, 32'hBFC00302);
        tick(); clr(); tick();

        // RI + OV together
        m_valid = 1; m_ri = 1; m_ov = 1; #1;
        chk("riov_type", exc_type, 6'h0a);
        chk("riov_bad", exc_badvaddr, 0);
        tick(); clr(); tick();

        // bubble with a fault flag set: nothing taken
        m_ov = 1; #1;
        chk("bubble_en", exc_en, 0);
        clr();

        // external interrupt through the synchroniser
        cp0_status = 32'h0000_0401; m_valid = 1; m_pc = 32'hBFC00500; ext_int = 6'b000001; #1;
        chk("int_e0", exc_en, 0);
        for (int i = 0; i < SYNC_STAGES - 1; i++) begin
            tick();
            chk("int_early", exc_en, 0);
        end
        tick();
        chk("int_pend", int_pending, 6'b000001);
        chk("int_en", exc_en, 1);
        chk("int_type", exc_type, 6'h00);
        chk("int_newpc", newpc, 32'hBFC00380);
        tick();
        chk("int_shadow", exc_en, 0);
        cp0_status = 32'h0000_0403; tick();
        chk("int_exl", exc_en, 0);
        cp0_status = 32'h0000_0401; m_valid = 0; #1;
        chk("int_bubble", exc_en, 0);
        ext_int = 0; cp0_status = 0; clr();
        for (int i = 0; i <= SYNC_STAGES; i++) tick();
        chk("int_clear", int_pending, 0);

        // ERET held by stall, fires on release
        m_valid = 1; m_eret = 1; cp0_epc = 32'hBFC00444; stall = 1;
        for (int i = 0; i < 3; i++) begin
            #1;
            chk("eret_stall_en", exc_en, 0);
            chk("eret_stall_pc", newpc, 0);
            tick();
        end
        stall = 0; #1;
        chk("eret_en", exc_en, 1);
        chk("eret_type", exc_type, 6'h0e);
        chk("eret_newpc", newpc, 32'hBFC00444);
        tick();
        chk("eret_once", exc_en, 0);
        clr(); tick();

        // reset in SHADOW, then a fresh break
        m_valid = 1; m_syscall = 1; m_pc = 32'hBFC00600; #1;
        chk("rs_sys", exc_en, 1);
        tick();
        rst = 1; #1;
        chk("rs_en", exc_en, 0);
        chk("rs_flushd", flush_d, 0);
        chk("rs_pc", exc_pc, 0);
        chk("rs_type", exc_type, 0);
        tick();
        rst = 0; clr(); m_valid = 1; m_break = 1; m_pc = 32'hBFC00700; #1;
        chk("rs_bp_en", exc_en, 1);
        chk("rs_bp_type", exc_type, 6'h09);
        tick(); clr(); tick();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/exc_detect.md
Name: exc_detect

Overview:
- Pipeline-side counterpart of the CP0 register file. Collects per-instruction exception flags and external interrupts at the memory (M) stage, prioritises them and drives the CP0 exception write port (en, exctype, pc, badvaddr, indelayslot).
- Reads back the CP0 Status, Cause and EPC to decide whether to take an interrupt and where to redirect fetch.
- Generates the pipeline flush and redirect PC, and holds the decision across memory stalls.

Parameters:
- EXC_VECTOR, 32'hBFC00380, redirect target for all exceptions other than ERET.
- SYNC_STAGES, 2, number of synchroniser flops on ext_int (valid range 1..3).

Ports:
- clk  in  1  clock
- rst  in  1  synchronous active-high reset
- m_valid  in  1  M stage holds a real instruction (not a bubble)
- m_pc  in  32  PC of the M-stage instruction
- m_indelayslot  in  1  M-stage instruction is in a delay slot
- m_adel_if  in  1  fetch address error (m_pc[1:0] != 0)
- m_ri  in  1  reserved instruction
- m_syscall  in  1  SYSCALL
- m_break  in  1  BREAK
- m_ov  in  1  arithmetic overflow
- m_eret  in  1  ERET
- m_ld_misalign  in  1  misaligned load
- m_st_misalign  in  1  misaligned store
- m_dataaddr  in  32  data address of the load/store
- ext_int  in  6  asynchronous hardware interrupt lines
- stall  in  1  pipeline stalled this cycle (memory wait)
- cp0_status  in  32  CP0 Status
- cp0_cause  in  32  CP0 Cause
- cp0_epc  in  32  CP0 EPC
- exc_en  out  1  CP0 exception write enable
- exc_type  out  6  exception code
- exc_pc  out  32  PC passed to CP0
- exc_indelayslot  out  1  delay-slot flag passed to CP0
- exc_badvaddr  out  32  faulting address passed to CP0
- flush  out  1  flush IF..M and redirect fetch this cycle
- flush_d  out  1  registered copy of flush, clears the M/W pipeline register on the following cycle
- newpc  out  32  redirect target, valid while flush=1
- int_pending  out  6  synchronised ext_int, for debug and for Cause.IP mirroring

Behaviour:
- Exception codes (defines2.vh values):
  - INT = 6'h00
  - ADEL = 6'h04
  - ADES = 6'h05
  - SYS = 6'h08
  - BP = 6'h09
  - RI = 6'h0a
  - OV = 6'h0c
  - ERET = EXC_TYPE_ERET
- Synchroniser: ext_int passes through SYNC_STAGES flops, reset to 0, to give int_pending.
- Interrupt request: int_req = cp0_status[0] & ~cp0_status[1] & |({int_pending, cp0_cause[9:8]} & cp0_status[15:8]).
- Priority (highest first), evaluated only when m_valid=1:
  1. int_req
  2. m_adel_if (ADEL)
  3. m_ri
  4. m_syscall
  5. m_break
  6. m_ov
  7. m_ld_misalign (ADEL)
  8. m_st_misalign (ADES)
  9. m_eret
- Hit: hit = m_valid & any source above.
- Combinational outputs, same cycle as the M-stage instruction:
  - exc_en = hit & ~stall & (state==IDLE).
  - exc_type = code of the winning source.
  - exc_pc = m_pc.
  - exc_indelayslot = m_indelayslot.
  - exc_badvaddr = m_pc for fetch ADEL; m_dataaddr for data ADEL/ADES; 0 otherwise.
- Redirect:
  - flush = exc_en.
  - newpc = cp0_epc when exc_type is ERET, else EXC_VECTOR; newpc = 0 when flush=0.
- FSM:
  - IDLE -> SHADOW when exc_en=1.
  - SHADOW -> IDLE unconditionally after 1 cycle.
  - In SHADOW, exc_en and flush are forced to 0. This prevents a second take while CP0 Status.EXL is still propagating and while the pipeline is flushing.
- flush_d is registered flush; reset value 0.
- Stall: while stall=1, exc_en, flush and newpc are 0. The winning decision is re-evaluated each cycle and fires on the first cycle with stall=0. An instruction is never reported twice.
- Bubbles: when m_valid=0, nothing is taken, including interrupts. An interrupt waits for the next valid instruction.
- Simultaneous sources: only the highest-priority code is reported; all others are dropped.
- Reset:
  - State = IDLE; synchroniser flops and flush_d are 0.
  - All outputs are 0 while rst=1, regardless of inputs.
  - rst asserted during SHADOW returns to IDLE on the next edge.

Test Plan:
- m_valid=1, m_syscall=1, m_pc=32'hBFC00100, stall=0 -> exc_en=1, exc_type=6'h08, flush=1, newpc=32'hBFC00380; next cycle flush_d=1 and exc_en=0 (SHADOW).
- m_ld_misalign=1, m_dataaddr=32'h80000003, m_pc=32'hBFC00200, m_indelayslot=1 -> exc_type=6'h04, exc_badvaddr=32'h80000003, exc_indelayslot=1, exc_pc=32'hBFC00200.
- m_ri=1 and m_ov=1 together -> exc_type=6'h0a only.
- ext_int=6'b000001, Status=32'h0000_0401 (IM2 set, IE=1, EXL=0), m_valid=1 -> exc_type=6'h00 exactly SYNC_STAGES cycles after ext_int rises. Same case with Status.EXL=1 -> no exception.
- m_eret=1, cp0_epc=32'hBFC00444, stall=1 for 3 cycles, then stall=0 -> exc_en=0 during the stall; one pulse on the release cycle with newpc=32'hBFC00444.
- m_syscall=1, then rst=1 in the following (SHADOW) cycle -> all outputs 0; after reset release, a fresh m_break=1 gives exc_type=6'h09 immediately.
